gcd_driver: RTL and testbench

Request-side controller for the GCD engine. It accepts operand pairs over a valid/ready handshake and launches each pair on the engine with a single-cycle start pulse. It waits for the engine's done pulse, or for a timeout, then returns the result on a valid/ready result port. It also resolves zero-operand requests locally, because the engine's swap/subtract loop never terminates when an operand is zero.

---
 rtl/gcd_driver_if.sv | 29 ++
 rtl/gcd_driver.sv | 98 +++++++++
 tb/tb_gcd_driver.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_driver_if.sv
// Bundles the request, engine and result signals of the GCD driver.
// Both op_* and res_* ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high; once raised, valid and its payload hold until that edge.
interface gcd_driver_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_result;
  logic             gcd_done;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  modport slave (
    input  op_valid, op_a, op_b, gcd_result, gcd_done, res_ready,
    output op_ready, gcd_a, gcd_b, gcd_start, res_valid, res_data, res_err
  );

  modport master (
    output op_valid, op_a, op_b, gcd_result, gcd_done, res_ready,
    input  op_ready, gcd_a, gcd_b, gcd_start, res_valid, res_data, res_err
  );
endinterface

// File: rtl/gcd_driver.sv
// Request-side controller for the GCD engine: launches operand pairs, waits for done or timeout,
// and answers zero-operand requests locally since the engine would never terminate on them.
module gcd_driver #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  gcd_driver_if.slave  bus,
  output logic         busy,
  output logic [1:0]   state
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        cur;
  state_t        nxt;
  logic [CW-1:0] count;
  logic          accept;
  logic          op_zero;
  logic          expired;

  assign accept  = (cur == IDLE) && bus.op_valid;
  assign op_zero = (bus.op_a == {WIDTH{1'b0}}) || (bus.op_b == {WIDTH{1'b0}});
  assign expired = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // gcd_done only matters in WAIT; a pulse arriving in ISSUE may belong to an older run.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (accept) nxt = op_zero ? RESP : ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (bus.gcd_done || expired) nxt = RESP;
      RESP:    if (bus.res_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.op_ready = (cur == IDLE);
    busy         = (cur != IDLE);
    state        = cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.gcd_start <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_err   <= 1'b0;
      bus.res_data  <= '0;
      bus.gcd_a     <= '0;
      bus.gcd_b     <= '0;
      count         <= '0;
    end else begin
      bus.gcd_start <= (nxt == ISSUE);
      bus.res_valid <= (nxt == RESP);
      case (cur)
        IDLE: begin
          if (accept) begin
            if (op_zero) begin
              // gcd(x,0) = x and gcd(0,0) = 0 both reduce to an OR.
              bus.res_data <= bus.op_a | bus.op_b;
              bus.res_err  <= 1'b0;
            end else begin
              bus.gcd_a <= bus.op_a;
              bus.gcd_b <= bus.op_b;
            end
          end
        end
        ISSUE: count <= '0;
        WAIT: begin
          if (bus.gcd_done) begin
            bus.res_data <= bus.gcd_result;
            bus.res_err  <= 1'b0;
          end else if (expired) begin
            bus.res_data <= '0;
            bus.res_err  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver: the bench plays the upstream requester, the GCD engine and the result sink.
module tb_gcd_driver;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         busy_a, busy_b;
  logic [1:0]   state_a, state_b;
  int           n_checks = 0;
  int           n_fail = 0;
  int           start_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  gcd_driver_if #(.WIDTH(W)) ia();
  gcd_driver_if #(.WIDTH(W)) ib();

  gcd_driver #(.WIDTH(W), .TIMEOUT(1024)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave), .busy(busy_a), .state(state_a)
  );

  gcd_driver #(.WIDTH(W), .TIMEOUT(8)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave), .busy(busy_b), .state(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (ia.gcd_start === 1'b1) start_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    if (x == 0) return y;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ia.op_valid = 0; ia.op_a = 0; ia.op_b = 0; ia.gcd_result = 0; ia.gcd_done = 0; ia.res_ready = 0;
    ib.op_valid = 0; ib.op_a = 0; ib.op_b = 0; ib.gcd_result = 0; ib.gcd_done = 0; ib.res_ready = 0;
  endtask

  // Returns one cycle after the accepting edge (cycle 1).
  task automatic send_a(input logic [W-1:0] a, input logic [W-1:0] b);
    ia.op_a = a;
    ia.op_b = b;
    ia.op_valid = 1;
    for (int i = 0; i < 32 && ia.op_ready !== 1'b1; i++) tick;
    n_checks++;
    if (ia.op_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: op_ready=%b, required 1 within 32 cycles", ia.op_ready);
    end
    tick;
    ia.op_valid = 0;
  endtask

  task automatic engine_a(input int delay, input logic [W-1:0] result);
    repeat (delay) tick;
    ia.gcd_result = result;
    ia.gcd_done = 1;
    tick;
    ia.gcd_done = 0;
  endtask

  task automatic collect_a(output logic [W-1:0] data, output logic err, output logic got);
    int waited;
    waited = 0;
    while (ia.res_valid !== 1'b1 && waited < 64) begin
      tick;
      waited++;
    end
    got = ia.res_valid;
    data = ia.res_data;
    err = ia.res_err;
    ia.res_ready = 1;
    tick;
    ia.res_ready = 0;
  endtask

  // tests
  task automatic test_reset;
    reset = 1;
    idle_inputs();
    tick;
    tick;
    n_checks++; if (ia.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_op_ready: got %b required 1", ia.op_ready); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_a); end
    n_checks++; if (state_a !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", state_a); end
    n_checks++; if (ia.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b required 0", ia.res_valid); end
    n_checks++; if (ia.gcd_start !== 1'b0) begin n_fail++; $display("FAIL reset_gcd_start: got %b required 0", ia.gcd_start); end
    n_checks++; if (ia.gcd_a !== 0 || ia.gcd_b !== 0) begin n_fail++; $display("FAIL reset_gcd_ab: got %0d,%0d required 0,0", ia.gcd_a, ia.gcd_b); end
    n_checks++; if (ia.res_data !== 0 || ia.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res: got data=%0d err=%b required 0,0", ia.res_data, ia.res_err); end
    n_checks++; if (state_b !== 2'd0 || ib.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b: got state=%0d op_ready=%b required 0,1", state_b, ib.op_ready); end
    reset = 0;
    tick;
  endtask

  task automatic test_basic;
    logic [W-1:0] d_exp;
    logic         e_exp;
    int           s0;
    exp_q.push_back(ref_gcd(48, 18));
    exp_err_q.push_back(1'b0);
    s0 = start_cnt;
    send_a(48, 18);
    n_checks++; if (ia.gcd_start !== 1'b1) begin n_fail++; $display("FAIL basic_start_c1: got %b required 1", ia.gcd_start); end
    n_checks++; if (ia.gcd_a !== 48 || ia.gcd_b !== 18) begin n_fail++; $display("FAIL basic_operands: got %0d,%0d required 48,18", ia.gcd_a, ia.gcd_b); end
    n_checks++; if (ia.op_ready !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got op_ready=%b busy=%b required 0,1", ia.op_ready, busy_a); end
    tick;
    n_checks++; if (ia.gcd_start !== 1'b0) begin n_fail++; $display("FAIL basic_start_c2: got %b required 0", ia.gcd_start); end
    for (int c = 2; c < 12; c++) begin
      n_checks++; if (ia.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: cycle %0d got %b required 0", c, ia.res_valid); end
      tick;
    end
    ia.gcd_result = 6;
    ia.gcd_done = 1;
    tick;
    ia.gcd_done = 0;
    d_exp = exp_q.pop_front();
    e_exp = exp_err_q.pop_front();
    n_checks++; if (ia.res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_c13: got %b required 1", ia.res_valid); end
    n_checks++; if (ia.res_data !== d_exp || ia.res_err !== e_exp) begin n_fail++; $display("FAIL basic_result: got %0d err=%b required %0d err=%b", ia.res_data, ia.res_err, d_exp, e_exp); end
    ia.res_ready = 1;
    tick;
    ia.res_ready = 0;
    n_checks++; if (ia.res_valid !== 1'b0 || ia.op_ready !== 1'b1) begin n_fail++; $display("FAIL basic_after_hs: got res_valid=%b op_ready=%b required 0,1", ia.res_valid, ia.op_ready); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL basic_start_count: got %0d required 1", start_cnt - s0); end
  endtask

  task automatic test_zero_bypass;
    logic [W-1:0] ta[3];
    logic [W-1:0] tb[3];
    logic [W-1:0] d_exp;
    int           s0;
    ta = '{0, 35, 0};
    tb = '{35, 0, 0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ref_gcd(ta[i], tb[i]));
      exp_err_q.push_back(1'b0);
      s0 = start_cnt;
      send_a(ta[i], tb[i]);
      d_exp = exp_q.pop_front();
      void'(exp_err_q.pop_front());
      n_checks++; if (ia.res_valid !== 1'b1 || ia.gcd_start !== 1'b0) begin n_fail++; $display("FAIL zero_c1_%0d: got res_valid=%b gcd_start=%b required 1,0", i, ia.res_valid, ia.gcd_start); end
      n_checks++; if (ia.res_data !== d_exp || ia.res_err !== 1'b0) begin n_fail++; $display("FAIL zero_data_%0d: got %0d err=%b required %0d err=0", i, ia.res_data, ia.res_err, d_exp); end
      ia.res_ready = 1;
      tick;
      ia.res_ready = 0;
      n_checks++; if (ia.res_valid !== 1'b0 || start_cnt != s0) begin n_fail++; $display("FAIL zero_after_%0d: got res_valid=%b starts=%0d required 0,0", i, ia.res_valid, start_cnt - s0); end
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] d_exp, d;
    logic         e, got;
    int           s0;
    exp_q.push_back(ref_gcd(48, 18));
    exp_err_q.push_back(1'b0);
    send_a(48, 18);
    engine_a(3, 6);
    d_exp = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    ia.op_a = 10;
    ia.op_b = 5;
    ia.op_valid = 1;
    exp_q.push_back(ref_gcd(10, 5));
    exp_err_q.push_back(1'b0);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (ia.res_valid !== 1'b1 || ia.res_data !== d_exp || ia.res_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d: got valid=%b data=%0d err=%b required 1,%0d,0", i, ia.res_valid, ia.res_data, ia.res_err, d_exp); end
      n_checks++; if (ia.op_ready !== 1'b0) begin n_fail++; $display("FAIL bp_op_ready_%0d: got %b required 0", i, ia.op_ready); end
      tick;
    end
    n_checks++; if (start_cnt != s0) begin n_fail++; $display("FAIL bp_no_start: got %0d starts required 0", start_cnt - s0); end
    ia.res_ready = 1;
    tick;
    ia.res_ready = 0;
    n_checks++; if (ia.op_ready !== 1'b1 || ia.res_valid !== 1'b0 || ia.gcd_start !== 1'b0) begin n_fail++; $display("FAIL bp_post_hs: got op_ready=%b res_valid=%b gcd_start=%b required 1,0,0", ia.op_ready, ia.res_valid, ia.gcd_start); end
    tick;
    ia.op_valid = 0;
    n_checks++; if (ia.gcd_start !== 1'b1 || ia.gcd_a !== 10 || ia.gcd_b !== 5) begin n_fail++; $display("FAIL bp_next_issue: got start=%b a=%0d b=%0d required 1,10,5", ia.gcd_start, ia.gcd_a, ia.gcd_b); end
    engine_a(2, ref_gcd(10, 5));
    collect_a(d, e, got);
    d_exp = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++; if (got !== 1'b1 || d !== d_exp || e !== 1'b0) begin n_fail++; $display("FAIL bp_second_result: got valid=%b data=%0d err=%b required 1,%0d,0", got, d, e, d_exp); end
  endtask

  task automatic test_timeout;
    logic [W-1:0] d_exp;
    logic         e_exp;
    exp_q.push_back(0);
    exp_err_q.push_back(1'b1);
    ib.op_a = 100;
    ib.op_b = 75;
    ib.op_valid = 1;
    n_checks++; if (ib.op_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b required 1", ib.op_ready); end
    tick;
    ib.op_valid = 0;
    n_checks++; if (ib.gcd_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b required 1", ib.gcd_start); end
    tick;
    for (int c = 2; c < 10; c++) begin
      n_checks++; if (ib.res_valid !== 1'b0) begin n_fail++; $display("FAIL to_early_valid: cycle %0d got %b required 0", c, ib.res_valid); end
      tick;
    end
    d_exp = exp_q.pop_front();
    e_exp = exp_err_q.pop_front();
    n_checks++; if (ib.res_valid !== 1'b1 || ib.res_data !== d_exp || ib.res_err !== e_exp) begin n_fail++; $display("FAIL to_result: got valid=%b data=%0d err=%b required 1,%0d,%b", ib.res_valid, ib.res_data, ib.res_err, d_exp, e_exp); end
    ib.gcd_result = 7;
    ib.gcd_done = 1;
    tick;
    n_checks++; if (ib.res_valid !== 1'b1 || ib.res_data !== d_exp || ib.res_err !== e_exp) begin n_fail++; $display("FAIL to_late_done_resp: got valid=%b data=%0d err=%b required 1,%0d,%b", ib.res_valid, ib.res_data, ib.res_err, d_exp, e_exp); end
    ib.res_ready = 1;
    tick;
    ib.res_ready = 0;
    tick;
    n_checks++; if (ib.res_valid !== 1'b0 || busy_b !== 1'b0 || ib.res_data !== 0) begin n_fail++; $display("FAIL to_late_done_idle: got valid=%b busy=%b data=%0d required 0,0,0", ib.res_valid, busy_b, ib.res_data); end
    ib.gcd_done = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] d_exp, d;
    logic         e, got;
    int           s0;
    send_a(40, 15);
    tick;
    tick;
    tick;
    reset = 1;
    tick;
    reset = 0;
    n_checks++; if (ia.op_ready !== 1'b1 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got op_ready=%b busy=%b required 1,0", ia.op_ready, busy_a); end
    n_checks++; if (ia.res_valid !== 1'b0 || ia.gcd_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs: got res_valid=%b gcd_start=%b required 0,0", ia.res_valid, ia.gcd_start); end
    ia.gcd_result = 5;
    ia.gcd_done = 1;
    tick;
    ia.gcd_done = 0;
    n_checks++; if (ia.res_valid !== 1'b0 || state_a !== 2'd0) begin n_fail++; $display("FAIL rst_stray_done: got res_valid=%b state=%0d required 0,0", ia.res_valid, state_a); end
    exp_q.push_back(ref_gcd(21, 14));
    exp_err_q.push_back(1'b0);
    s0 = start_cnt;
    send_a(21, 14);
    engine_a(4, ref_gcd(21, 14));
    collect_a(d, e, got);
    d_exp = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++; if (got !== 1'b1 || d !== d_exp || e !== 1'b0) begin n_fail++; $display("FAIL rst_new_request: got valid=%b data=%0d err=%b required 1,%0d,0", got, d, e, d_exp); end
    n_checks++; if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL rst_start_count: got %0d required 1", start_cnt - s0); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d_exp, d;
    logic         e, got;
    int           s0;
    exp_q.push_back(ref_gcd(12, 8));
    exp_err_q.push_back(1'b0);
    exp_q.push_back(ref_gcd(9, 6));
    exp_err_q.push_back(1'b0);
    s0 = start_cnt;
    send_a(12, 8);
    engine_a(3, ref_gcd(12, 8));
    ia.res_ready = 1;
    ia.op_a = 9;
    ia.op_b = 6;
    ia.op_valid = 1;
    d_exp = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++; if (ia.res_valid !== 1'b1 || ia.res_data !== d_exp) begin n_fail++; $display("FAIL b2b_first: got valid=%b data=%0d required 1,%0d", ia.res_valid, ia.res_data, d_exp); end
    n_checks++; if (ia.op_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_hs_ready: got %b required 0", ia.op_ready); end
    tick;
    ia.res_ready = 0;
    n_checks++; if (ia.op_ready !== 1'b1 || ia.gcd_start !== 1'b0 || ia.res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: got op_ready=%b start=%b valid=%b required 1,0,0", ia.op_ready, ia.gcd_start, ia.res_valid); end
    tick;
    ia.op_valid = 0;
    n_checks++; if (ia.gcd_start !== 1'b1 || ia.gcd_a !== 9 || ia.gcd_b !== 6) begin n_fail++; $display("FAIL b2b_second_issue: got start=%b a=%0d b=%0d required 1,9,6", ia.gcd_start, ia.gcd_a, ia.gcd_b); end
    engine_a(3, ref_gcd(9, 6));
    collect_a(d, e, got);
    d_exp = exp_q.pop_front();
    void'(exp_err_q.pop_front());
    n_checks++; if (got !== 1'b1 || d !== d_exp || e !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got valid=%b data=%0d err=%b required 1,%0d,0", got, d, e, d_exp); end
    n_checks++; if (start_cnt - s0 !== 2) begin n_fail++; $display("FAIL b2b_start_count: got %0d required 2", start_cnt - s0); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_bypass();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
